seq_detect_scheduler: RTL
=========================

// Module: seq_detect_scheduler
// PURPOSE
//  Time-shares one Mealy "0110" sequence-detector datapath among NCH serial bit streams.
//  A round-robin scheduler accepts at most one bit per cycle from a requesting channel.
//  Per cycle: load that channel's saved detector state, evaluate the Mealy transition, write the state back.
//  Sits between the serial front-ends and the match-event logger; replaces NCH separate detector instances.
// PARAMETERS
//  NCH      4        number of input channels (2..16)
//  PATTERN  4'b0110  target sequence; MSB is received first
//  PLEN     4        pattern length in bits (2..8)
//  OVERLAP  0        1 = overlapping detection, 0 = restart after each match
// PORTS
//  clk          in   1             rising-edge clock
//  reset        in   1             asynchronous, active-high reset
//  chan_en      in   NCH           per-channel enable; a disabled channel is never granted
//  clear        in   1             synchronous clear of the state table and the counter
//  bit_in       in   NCH           serial data bit, one per channel
//  bit_valid    in   NCH           channel has a bit pending
//  bit_ready    out  NCH           one-hot grant; bit transfers when valid & ready
//  match_valid  out  1             one-cycle pulse: the accepted bit completed PATTERN
//  match_ch     out  clog2(NCH)    channel index of that match
//  match_total  out  16            saturating count of all matches
// BEHAVIOUR
//  - Reset: match_valid=0, match_ch=0, match_total=0, all channel states=0, rr pointer=0.
//    bit_ready is combinational and is 0 while reset is asserted.
//  - State table: one entry per channel, width clog2(PLEN) bits.
//    The entry holds the count of pattern-prefix bits matched so far.
//    Example for 0110: S0 = none, S1 = "0", S2 = "01", S3 = "011".
//  - Arbitration (combinational):
//    - Eligible channels: bit_valid & chan_en.
//    - Grant the first eligible channel at or after the rr pointer, searching upward and wrapping.
//    - bit_ready = one-hot of the grant; all zeros if no channel is eligible or clear=1.
//    - On a handshake, rr pointer <= (granted channel + 1) mod NCH.
//  - Transition (for the granted channel g, with s = state[g] and b = bit_in[g]):
//    - If b equals PATTERN bit s and s < PLEN-1: state[g] <= s+1.
//    - If b equals PATTERN bit s and s == PLEN-1 (full match):
//      - Set the match flag.
//      - OVERLAP=0: state[g] <= 0.
//      - OVERLAP=1: state[g] <= longest proper prefix of PATTERN that is also a suffix of PATTERN
//        (value 1 for 0110).
//    - Otherwise: state[g] <= longest prefix of PATTERN that is a suffix of (matched prefix + b).
//      For 0110: S1 + 0 -> S1; S2 + 0 -> S1; S3 + 1 -> S0; S0 + 1 -> S0.
//    - The fallback table is computed at elaboration time by a constant function.
//  - Output latency: match_valid and match_ch are registered and assert the cycle after the accepting edge.
//    match_valid is held for exactly one cycle per match; it is 0 in every other cycle.
//  - match_total increments on each match and saturates at 16'hFFFF.
//  - Untouched states: states of non-granted channels are unchanged; bits sitting on them are not consumed.
//  - chan_en: while chan_en[i]=0, state[i] is forced to 0 on every clock edge.
//  - clear=1 (same cycle):
//    - No handshake occurs.
//    - All states <= 0, match_total <= 0, match_valid <= 0.
//    - rr pointer is held.
//  - Reset asserted mid-stream: all state is lost immediately, with no match_valid for partial sequences.
//  - With NCH channels all valid, each channel is granted exactly once every NCH cycles.
// TESTING
//  - Reset, then ch0 alone sends 0,1,1,0 -> one match_valid with match_ch=0 the cycle after bit 4; match_total=1.
//  - OVERLAP=0, ch1 sends 0110110 -> exactly 1 match.
//    Same stream with OVERLAP=1 -> 2 matches; the second pulse follows the 7th bit.
//  - All 4 channels continuously valid -> grants cycle 0,1,2,3,0...
//    Interleaved 0110 streams -> each channel matches once, with no cross-channel corruption.
//  - Fallback paths on ch2, stream 0,0,1,1,1,0,1,1,0:
//    exercises S1+0 and S3+1 -> exactly one match, after the last bit.
//  - ch3 has sent 0,1,1, then clear=1 for one cycle, then sends 0 -> no match; state[3]=S1; match_total=0.
//    Repeat, dropping chan_en[3] instead of pulsing clear -> same result, and bit_ready[3]=0 while disabled.
//  - Preload match_total=16'hFFFE via 2 more matches -> holds at 16'hFFFF.
//    Assert reset async mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
// Time-shared Mealy pattern detector: one transition datapath serves NCH serial streams,
// picking one requesting channel per cycle by round robin and keeping a per-channel state table.
module seq_detect_scheduler #(
  parameter int         NCH     = 4,
  parameter logic [7:0] PATTERN = 8'b0000_0110,
  parameter int         PLEN    = 4,
  parameter bit         OVERLAP = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         chan_en,
  input  logic                   clear,
  input  logic [NCH-1:0]         bit_in,
  input  logic [NCH-1:0]         bit_valid,
  output logic [NCH-1:0]         bit_ready,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  output logic [15:0]            match_total
);

  localparam int SW = $clog2(PLEN);
  localparam int CW = $clog2(NCH);

  // Pattern bit i in arrival order (bit 0 is received first).
  function automatic logic pat_bit(input int i);
    return |(PATTERN & (8'd1 << (PLEN - 1 - i)));
  endfunction

  // Longest k <= maxk such that the first k pattern bits equal the last k bits
  // of the sequence (first s pattern bits, then b).
  function automatic int border(input int s, input logic b, input int maxk);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k <= maxk; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        pos = s + 1 - k + j;
        sb  = (pos == s) ? b : pat_bit(pos);
        if (sb != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  function automatic logic [2*PLEN*SW-1:0] build_fb();
    logic [2*PLEN*SW-1:0] t;
    t = '0;
    for (int s = 0; s < PLEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        t[(2*s+b)*SW +: SW] = SW'(border(s, (b == 1), s));
      end
    end
    return t;
  endfunction

  // Mismatch fallback, indexed by {state, bit}; and the restart state after an overlapping match.
  localparam logic [2*PLEN*SW-1:0] FB  = build_fb();
  localparam int                   OVL = border(PLEN - 1, pat_bit(PLEN - 1), PLEN - 1);

  logic [SW-1:0] state_q [NCH];
  logic [CW-1:0] rr_q;
  logic          grant_found;
  logic [CW-1:0] grant_ch;
  logic [CW-1:0] ci;
  logic          hs;
  logic [SW-1:0] cur_s;
  logic          cur_b;
  logic          exp_b;
  logic          full;
  logic          hit;
  logic [SW-1:0] fb_s;
  logic [SW-1:0] next_s;

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    ci          = '0;
    for (int i = 0; i < NCH; i++) begin
      ci = CW'((int'(rr_q) + i) % NCH);
      if (!grant_found && bit_valid[ci] && chan_en[ci]) begin
        grant_found = 1'b1;
        grant_ch    = ci;
      end
    end
  end

  // Handshake: a bit moves on a rising edge where bit_valid[i] & bit_ready[i];
  // bit_ready is a one-hot grant, never raised for a disabled channel, during clear or reset.
  always_comb begin
    bit_ready = '0;
    if (grant_found && !clear && !reset) bit_ready[grant_ch] = 1'b1;
  end

  assign hs = |(bit_ready & bit_valid);

  always_comb begin
    cur_s = state_q[grant_ch];
    cur_b = bit_in[grant_ch];
    exp_b = 1'b0;
    fb_s  = '0;
    for (int k = 0; k < PLEN; k++) begin
      if (cur_s == SW'(k)) exp_b = pat_bit(k);
    end
    for (int k = 0; k < 2 * PLEN; k++) begin
      if ({cur_s, cur_b} == (SW+1)'(k)) fb_s = FB[k*SW +: SW];
    end
    full = (cur_s == SW'(PLEN - 1));
    hit  = (cur_b == exp_b) && full;
    if (cur_b != exp_b)  next_s = fb_s;
    else if (!full)      next_s = cur_s + SW'(1);
    else if (OVERLAP)    next_s = SW'(OVL);
    else                 next_s = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= '0;
      rr_q        <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      match_total <= '0;
    end else begin
      match_valid <= 1'b0;
      if (clear) begin
        for (int i = 0; i < NCH; i++) state_q[i] <= '0;
        match_total <= '0;
      end else begin
        if (hs) begin
          state_q[grant_ch] <= next_s;
          rr_q <= (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + CW'(1);
          if (hit) begin
            match_valid <= 1'b1;
            match_ch    <= grant_ch;
            if (match_total != 16'hFFFF) match_total <= match_total + 16'd1;
          end
        end
        // Disabled channels restart from scratch when re-enabled.
        for (int i = 0; i < NCH; i++) begin
          if (!chan_en[i]) state_q[i] <= '0;
        end
      end
    end
  end

endmodule
